// File: rtl/execute_cycle_stage.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding, ALU, branch resolve, E/M register.
// Optional EXEC_FLUSH_EN adds a FlushE input that turns the E/M entry into a bubble.
module execute_cycle_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteE,
    input  logic              ALUSrcE,
    input  logic              MemWriteE,
    input  logic              ResultSrcE,
    input  logic              BranchE,
    input  logic [2:0]        ALUControlE,
    input  logic [DATA_W-1:0] RD1_E,
    input  logic [DATA_W-1:0] RD2_E,
    input  logic [DATA_W-1:0] Imm_Ext_E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [DATA_W-1:0] PCE,
    input  logic [DATA_W-1:0] PCPlus4E,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [1:0]        ForwardA_E,
    input  logic [1:0]        ForwardB_E,
`ifdef EXEC_FLUSH_EN
    input  logic              FlushE,
`endif
    output logic              PCSrcE,
    output logic [DATA_W-1:0] PCTargetE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              ResultSrcM,
    output logic [REG_AW-1:0] RD_M,
    output logic [DATA_W-1:0] PCPlus4M,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ALU_ResultM
);

    logic              reg_write_q, reg_write_d;
    logic              mem_write_q, mem_write_d;
    logic              result_src_q, result_src_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] pc_plus4_q;
    logic [DATA_W-1:0] write_data_q;
    logic [DATA_W-1:0] alu_result_q;

    logic [DATA_W-1:0] src_a, rd2_f, src_b, alu_result;
    logic              zero;
    logic              kill;

    // Select 10 feeds back the E/M register so a dependent op one cycle behind sees its producer.
    always_comb begin
        src_a = RD1_E;
        case (ForwardA_E)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = alu_result_q;
            default: src_a = RD1_E;
        endcase
        rd2_f = RD2_E;
        case (ForwardB_E)
            2'b01:   rd2_f = ResultW;
            2'b10:   rd2_f = alu_result_q;
            default: rd2_f = RD2_E;
        endcase
        src_b = ALUSrcE ? Imm_Ext_E : rd2_f;
    end

    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b101:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
    end

    assign zero      = (alu_result == '0);
    assign PCSrcE    = BranchE & zero;
    assign PCTargetE = PCE + Imm_Ext_E;

`ifdef EXEC_FLUSH_EN
    assign kill = FlushE;
`else
    assign kill = 1'b0;
`endif

    // A flush only clears the side-effecting control and destination; data fields load normally.
    always_comb begin
        reg_write_d  = RegWriteE;
        mem_write_d  = MemWriteE;
        result_src_d = ResultSrcE;
        rd_d         = RD_E;
        if (kill) begin
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            result_src_d = 1'b0;
            rd_d         = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
            write_data_q <= '0;
            alu_result_q <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= PCPlus4E;
            write_data_q <= rd2_f;
            alu_result_q <= alu_result;
        end
    end

    assign RegWriteM   = reg_write_q;
    assign MemWriteM   = mem_write_q;
    assign ResultSrcM  = result_src_q;
    assign RD_M        = rd_q;
    assign PCPlus4M    = pc_plus4_q;
    assign WriteDataM  = write_data_q;
    assign ALU_ResultM = alu_result_q;

endmodule
